// File: rtl/control_booth.sv
// Radix-2 Booth sequencer for signed ancho x ancho multiplication.
// The iteration count comes from an external down counter: this block
// reloads it in CARGA, steps it once per shift, and polls its `fin`
// flag between iterations.
module control_booth #(
  parameter int ancho = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inicio,
  input  logic signed [ancho-1:0]   multiplicando,
  input  logic signed [ancho-1:0]   multiplicador,
  input  logic                      fin_cnt,
  output logic                      ini_cnt,
  output logic                      hab_cnt,
  output logic        [ancho-2:0]   n_cnt,
  output logic signed [2*ancho-1:0] producto,
  output logic                      ocupado,
  output logic                      listo
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CARGA  = 3'd1,
    EVAL   = 3'd2,
    DESPL  = 3'd3,
    REVISA = 3'd4,
    FIN    = 3'd5
  } state_t;

  // The counter counts down from ancho-1 to zero, so it sees ancho steps.
  localparam int unsigned NUM_INI = ancho - 1;

  state_t                 state;
  // A has one guard bit, so M = -2^(ancho-1) can be added or subtracted
  // without overflow.
  logic signed [ancho:0]  a;
  logic signed [ancho:0]  m_ext;
  logic        [ancho-1:0] m;
  logic        [ancho-1:0] q;
  logic                   q_1;

  assign m_ext = {m[ancho-1], m};
  assign n_cnt = NUM_INI[ancho-2:0];

  // The counter controls are decoded from the state, so each is high for
  // exactly one cycle per visit and the two can never overlap.
  assign ini_cnt = (state == CARGA);
  assign hab_cnt = (state == DESPL);

  // Sequencer, datapath and registered status outputs.
  // NOTE: all state uses non-blocking assignments, so every right-hand side
  // reads the value from before this edge. EVAL and DESPL depend on that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      m        <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      producto <= '0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (inicio) begin
            state   <= CARGA;
            ocupado <= 1'b1;
          end
        end
        CARGA: begin
          m     <= multiplicando;
          q     <= multiplicador;
          a     <= '0;
          q_1   <= 1'b0;
          state <= EVAL;
        end
        EVAL: begin
          case ({q[0], q_1})
            2'b01:   a <= a + m_ext;
            2'b10:   a <= a - m_ext;
            default: a <= a;
          endcase
          state <= DESPL;
        end
        DESPL: begin
          a     <= {a[ancho], a[ancho:1]};
          q     <= {a[0], q[ancho-1:1]};
          q_1   <= q[0];
          state <= REVISA;
        end
        REVISA: begin
          if (fin_cnt) begin
            // Load the result on entry to FIN so it is valid alongside listo.
            producto <= {a[ancho-1:0], q};
            listo    <= 1'b1;
            state    <= FIN;
          end else begin
            state <= EVAL;
          end
        end
        FIN: begin
          ocupado <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ocupado <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_booth.sv
// Directed bench for control_booth (ancho = 4). It includes a behavioural
// model of the downstream down counter. Stimulus is driven on the falling
// edge, and outputs are sampled on the falling edge as well.
module tb_control_booth;

  localparam int ANCHO = 4;

  logic                      clk;
  logic                      rst;
  logic                      inicio;
  logic signed [ANCHO-1:0]   multiplicando;
  logic signed [ANCHO-1:0]   multiplicador;
  logic                      fin_cnt;
  logic                      ini_cnt;
  logic                      hab_cnt;
  logic        [ANCHO-2:0]   n_cnt;
  logic signed [2*ANCHO-1:0] producto;
  logic                      ocupado;
  logic                      listo;

  int passed = 0;
  int total  = 0;

  // Running event counts, used by the tests as before/after snapshots.
  int hab_n     = 0;
  int ini_n     = 0;
  int listo_n   = 0;
  int overlap_n = 0;

  control_booth #(.ancho(ANCHO)) dut (
    .clk           (clk),
    .rst           (rst),
    .inicio        (inicio),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .fin_cnt       (fin_cnt),
    .ini_cnt       (ini_cnt),
    .hab_cnt       (hab_cnt),
    .n_cnt         (n_cnt),
    .producto      (producto),
    .ocupado       (ocupado),
    .listo         (listo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Down counter model: load n_i on inicializar, then raise fin on the
  // habilitar pulse that finds the count already at zero.
  logic [ANCHO-2:0] cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      fin_cnt <= 1'b0;
    end else if (ini_cnt) begin
      cnt     <= n_cnt;
      fin_cnt <= 1'b0;
    end else if (hab_cnt) begin
      if (cnt == '0) fin_cnt <= 1'b1;
      else           cnt     <= cnt - 1'b1;
    end
  end

  // Count control pulses mid-cycle.
  always @(negedge clk) begin
    if (hab_cnt) hab_n++;
    if (ini_cnt) ini_n++;
    if (listo) listo_n++;
    if (hab_cnt && ini_cnt) overlap_n++;
  end

  // Start an operation and wait for listo, with a bounded wait.
  // Cycle 0 is the IDLE cycle in which inicio is sampled.
  // The result is lat=-1 if listo never arrives.
  task automatic do_op(input logic signed [ANCHO-1:0] mv, input logic signed [ANCHO-1:0] qv,
                       input bit repulse, output int lat, output logic [2*ANCHO-1:0] p,
                       output bit busy_ok, output bit idle_ok);
    @(negedge clk);
    multiplicando = mv;
    multiplicador = qv;
    inicio        = 1'b1;
    lat     = -1;
    p       = '0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) inicio = 1'b0;
      if (repulse && k == 7) begin
        multiplicando = 4'sd7;
        multiplicador = 4'sd7;
        inicio        = 1'b1;
      end
      if (repulse && k == 8) inicio = 1'b0;
      if (ocupado !== 1'b1) busy_ok = 1'b0;
      if (listo === 1'b1) begin
        lat = k;
        p   = producto;
      end
    end
    @(negedge clk);
    idle_ok = (ocupado === 1'b0) && (listo === 1'b0) && (producto === p);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    inicio = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    repeat (2) @(negedge clk);
    total++; if (producto !== 8'h00) $display("FAIL reset_producto got %h want 00", producto); else passed++;
    total++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado got %b want 0", ocupado); else passed++;
    total++; if (listo !== 1'b0) $display("FAIL reset_listo got %b want 0", listo); else passed++;
    total++; if ({ini_cnt, hab_cnt} !== 2'b00) $display("FAIL reset_cnt_ctl got %b want 00", {ini_cnt, hab_cnt}); else passed++;
    total++; if (n_cnt !== 3'd3) $display("FAIL reset_n_cnt got %0d want 3", n_cnt); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (ocupado !== 1'b0) $display("FAIL post_reset_ocupado got %b want 0", ocupado); else passed++;
  endtask

  task automatic test_basic();
    int lat; logic [7:0] p; bit b, i;
    do_op(4'sd3, -4'sd2, 1'b0, lat, p, b, i);
    total++; if (lat !== 14) $display("FAIL basic_latency got %0d want 14", lat); else passed++;
    total++; if (p !== 8'hFA) $display("FAIL basic_producto got %h want FA", p); else passed++;
    total++; if (b !== 1'b1) $display("FAIL basic_ocupado_1_14 got %b want 1", b); else passed++;
    total++; if (i !== 1'b1) $display("FAIL basic_idle_after got %b want 1", i); else passed++;
  endtask

  task automatic test_corners();
    int lat; logic [7:0] p; bit b, i;
    do_op(-4'sd8, -4'sd8, 1'b0, lat, p, b, i);
    total++; if (p !== 8'h40) $display("FAIL min_sq_producto got %h want 40", p); else passed++;
    total++; if (lat !== 14) $display("FAIL min_sq_latency got %0d want 14", lat); else passed++;
    do_op(4'sd7, -4'sd8, 1'b0, lat, p, b, i);
    total++; if (p !== 8'hC8) $display("FAIL max_min_producto got %h want C8", p); else passed++;
    do_op(-4'sd1, -4'sd1, 1'b0, lat, p, b, i);
    total++; if (p !== 8'h01) $display("FAIL neg1_sq_producto got %h want 01", p); else passed++;
  endtask

  task automatic test_zero_counts();
    int lat; logic [7:0] p; bit b, i;
    int h0, i0, o0;
    h0 = hab_n; i0 = ini_n; o0 = overlap_n;
    do_op(4'sd0, 4'sd5, 1'b0, lat, p, b, i);
    total++; if (p !== 8'h00) $display("FAIL zero_producto got %h want 00", p); else passed++;
    total++; if (hab_n - h0 !== 4) $display("FAIL zero_hab_pulses got %0d want 4", hab_n - h0); else passed++;
    total++; if (ini_n - i0 !== 1) $display("FAIL zero_ini_pulses got %0d want 1", ini_n - i0); else passed++;
    total++; if (overlap_n - o0 !== 0) $display("FAIL zero_ini_hab_overlap got %0d want 0", overlap_n - o0); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] p; bit b, i;
    int l0;
    l0 = listo_n;
    @(negedge clk);
    multiplicando = 4'sd5;
    multiplicador = 4'sd5;
    inicio        = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) inicio = 1'b0;
    end
    rst = 1'b1;
    #1;
    total++; if (producto !== 8'h00) $display("FAIL midrst_producto got %h want 00", producto); else passed++;
    total++; if (ocupado !== 1'b0) $display("FAIL midrst_ocupado got %b want 0", ocupado); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (listo_n - l0 !== 0) $display("FAIL midrst_no_listo got %0d want 0", listo_n - l0); else passed++;
    total++; if (producto !== 8'h00) $display("FAIL midrst_producto_hold got %h want 00", producto); else passed++;
    do_op(4'sd5, 4'sd5, 1'b0, lat, p, b, i);
    total++; if (p !== 8'h19) $display("FAIL midrst_restart_producto got %h want 19", p); else passed++;
    total++; if (lat !== 14) $display("FAIL midrst_restart_latency got %0d want 14", lat); else passed++;
  endtask

  task automatic test_ignore_inicio();
    int lat; logic [7:0] p; bit b, i;
    do_op(4'sd2, 4'sd3, 1'b1, lat, p, b, i);
    total++; if (p !== 8'h06) $display("FAIL ignore_producto got %h want 06", p); else passed++;
    total++; if (lat !== 14) $display("FAIL ignore_latency got %0d want 14", lat); else passed++;
    total++; if (i !== 1'b1) $display("FAIL ignore_idle_after got %b want 1", i); else passed++;
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic [7:0] p1, p2;
    first = -1; second = -1; p1 = '0; p2 = '0;
    @(negedge clk);
    multiplicando = 4'sd3;
    multiplicador = 4'sd3;
    inicio        = 1'b1;
    for (int k = 1; k <= 45 && second < 0; k++) begin
      @(negedge clk);
      if (k == 2) begin
        multiplicando = -4'sd1;
        multiplicador = 4'sd5;
      end
      if (listo === 1'b1) begin
        if (first < 0) begin first = k; p1 = producto; end
        else begin second = k; p2 = producto; inicio = 1'b0; end
      end
    end
    inicio = 1'b0;
    total++; if (first !== 14) $display("FAIL b2b_first_latency got %0d want 14", first); else passed++;
    total++; if (second - first !== 15) $display("FAIL b2b_spacing got %0d want 15", second - first); else passed++;
    total++; if (p1 !== 8'h09) $display("FAIL b2b_first_producto got %h want 09", p1); else passed++;
    total++; if (p2 !== 8'hFB) $display("FAIL b2b_second_producto got %h want FB", p2); else passed++;
    repeat (2) @(negedge clk);
    total++; if (ocupado !== 1'b0) $display("FAIL b2b_stops_after_release got %b want 0", ocupado); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_zero_counts();
    test_reset_mid();
    test_ignore_inicio();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
